mux_int_initiator: RTL
======================

Name: mux_int_initiator

Overview:
Requester-side agent for the two-input mux_int select/data/response interface. Queues 32-bit words pushed by local logic and presents them one at a time on a sel/data pair. Holds each request until the mux returns resp, or until a timeout expires. One instance drives each mux_int input (in_data1/in_sel1, in_data2/in_sel2).

Parameters:
DEPTH, 4, word queue depth (power of 2, >= 2)
TIMEOUT, 15, max cycles req_sel stays high without resp (>= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
push  input  1  enqueue push_data this cycle
push_data  input  [0:31]  word to enqueue (bit 0 = MSB, codebase bit order)
full  output  1  queue holds DEPTH entries; push ignored
empty  output  1  queue holds 0 entries
req_sel  output  1  request valid, to mux in_selN
req_data  output  [0:31]  request word, to mux in_dataN
resp  input  1  mux response for this requester
busy  output  1  state != IDLE
timeout_err  output  1  one-cycle pulse when a request is abandoned
done_cnt  output  [0:7]  completed-request count, wraps 255 -> 0

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (async, any state):
  - queue emptied; full=0, empty=1
  - req_sel=0, req_data=0, busy=0, timeout_err=0, done_cnt=0, state=IDLE, timer=0
  - reset mid-request drops req_sel immediately; the in-flight word is lost.
- All outputs are registered except full and empty, which decode the count combinationally.
- Queue:
  - push accepted at an edge only if full=0 at that edge; a pop in the same cycle does not free a slot for that push.
  - Push while full is dropped silently.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, REQ, GAP.
  - IDLE:
    - count>0 at edge -> REQ; req_sel<=1; req_data<=head; timer<=0.
    - A word pushed at edge N raises req_sel at edge N+1.
  - REQ:
    - req_data is stable for the whole REQ stay.
    - resp=1 at edge -> pop head, done_cnt+1, req_sel<=0, req_data<=0 -> GAP.
    - else if timer==TIMEOUT-1 -> pop head (word discarded), timeout_err<=1 for one cycle, req_sel<=0, req_data<=0 -> GAP.
    - else timer+1.
    - req_sel is high for at most TIMEOUT cycles.
  - GAP:
    - Exactly one cycle with req_sel=0; gives the mux a falling sel edge before rearbitration.
    - count>0 -> REQ (load new head, timer<=0); else -> IDLE.
- Simultaneous events:
  - resp and timeout on the same edge: resp wins (success, no error pulse).
  - resp while in IDLE or GAP is ignored.
- Back-to-back words: req_sel high(k cycles) / low(1 cycle) / high. Minimum period 2 cycles per word when resp is returned on the first REQ cycle.
- busy=1 in REQ and GAP.

Test Plan:
- Reset then push 4096 at edge 1, resp=1 on the 3rd REQ cycle:
  - req_sel rises at edge 2 with req_data=4096
  - req_sel falls after the resp edge; done_cnt=1; empty=1 after the pop.
- Push 1234, 5678, 2048 back-to-back; hold resp=1 constantly:
  - req_data sequence 1234, 5678, 2048, each high 1 cycle, 1-cycle gaps
  - done_cnt=3; timeout_err never pulses.
- Push 1024, keep resp=0 with TIMEOUT=15:
  - req_sel high exactly 15 cycles, then timeout_err pulses once
  - queue empty; done_cnt unchanged.
- Push 5 words with DEPTH=4 while resp=0:
  - full=1 after the 4th push; 5th word never appears on req_data
  - afterwards drive resp=1: exactly 4 words emerge in push order.
- Assert resp exactly on the timeout cycle (15th REQ cycle):
  - counted as success: done_cnt+1, no timeout_err.
- Drop rst_n mid-REQ with req_data=2048, 2 words queued:
  - req_sel=0 immediately, empty=1, done_cnt=0
  - after release no request issues until a new push.

Source files
------------

// File: rtl/mux_int_initiator.sv
// mux_int_initiator: requester-side agent for one mux_int input.
// Buffers pushed 32-bit words in a small FIFO and offers them one at a time
// on req_sel/req_data, holding each until resp or until a timeout expires.
// A one-cycle GAP with req_sel low always follows each request, so that the
// mux sees a falling select edge before it re-arbitrates.
module mux_int_initiator #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [0:31] push_data,
    output logic        full,
    output logic        empty,
    output logic        req_sel,
    output logic [0:31] req_data,
    input  logic        resp,
    output logic        busy,
    output logic        timeout_err,
    output logic [0:7]  done_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t        state, state_nxt;

    logic [0:31]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop;

    logic [TW-1:0] timer, timer_nxt;
    logic          req_sel_nxt;
    logic [0:31]   req_data_nxt;
    logic          timeout_err_nxt;
    logic [0:7]    done_cnt_nxt;
    logic          busy_nxt;

    // full/empty decode the occupancy directly; push uses the pre-pop view.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;

    // Word storage: written on accepted push only, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: resp takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count != '0) state_nxt = REQ;
            REQ: begin
                if (resp || timer == TW'(TIMEOUT - 1)) begin
                    state_nxt = GAP;
                end
            end
            GAP: state_nxt = (count != '0) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/next-value logic for the registered outputs, plus the pop strobe.
    always_comb begin
        pop             = 1'b0;
        req_sel_nxt     = req_sel;
        req_data_nxt    = req_data;
        timer_nxt       = timer;
        timeout_err_nxt = 1'b0;
        done_cnt_nxt    = done_cnt;
        case (state)
            IDLE, GAP: begin
                req_sel_nxt  = 1'b0;
                req_data_nxt = '0;
                if (count != '0) begin
                    req_sel_nxt  = 1'b1;
                    req_data_nxt = mem[rd_ptr];
                    timer_nxt    = '0;
                end
            end
            REQ: begin
                if (resp) begin
                    pop          = 1'b1;
                    done_cnt_nxt = done_cnt + 8'd1;
                    req_sel_nxt  = 1'b0;
                    req_data_nxt = '0;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    pop             = 1'b1;
                    timeout_err_nxt = 1'b1;
                    req_sel_nxt     = 1'b0;
                    req_data_nxt    = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                req_sel_nxt  = 1'b0;
                req_data_nxt = '0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sel     <= 1'b0;
            req_data    <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
            done_cnt    <= '0;
            busy        <= 1'b0;
        end else begin
            req_sel     <= req_sel_nxt;
            req_data    <= req_data_nxt;
            timer       <= timer_nxt;
            timeout_err <= timeout_err_nxt;
            done_cnt    <= done_cnt_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule
